burst_mem_responder: RTL and testbench

Synthesizable responder for the cache-line burst memory port of the `mp3` core: it sits on the far side of `address_o`/`read_o`/`write_o`/`burst_o`/`burst_i`/`resp_i` and services 32-byte line reads and writes as four 64-bit beats. It holds a small line-organized storage array and imposes a programmable access latency. It is used as on-chip backing memory in FPGA builds and as a cycle-accurate memory model in core regressions.

---
 rtl/burst_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_burst_mem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: line-organized backing memory for a cache-line burst port.
// Each 32-byte line transfers as four 64-bit beats, beat 0 first. The first beat
// arrives LATENCY cycles after the request is accepted.
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous active-low reset
//   address_i  line address; bits [4:0] ignored, upper bits alias
//   read_i     line read request, held until the last beat
//   write_i    line write request, held until the last beat
//   burst_i    write beat data
//   burst_o    read beat data, zero outside read beats
//   resp_o     beat strobe, four consecutive cycles per transaction
//   error_o    sticky protocol-violation flag, cleared only by reset
module burst_mem_responder #(
    parameter int unsigned DEPTH_LINES = 256,
    parameter int unsigned LATENCY     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [63:0] burst_i,
    output logic [63:0] burst_o,
    output logic        resp_o,
    output logic        error_o
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_LINES);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BEAT_W = 64;
    localparam int unsigned BEATS  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_DONE
    } state_t;

    typedef logic [BEATS-1:0][BEAT_W-1:0] line_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         beat_q, beat_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wr_q, wr_d;
    line_t              line_q, line_d;
    logic               resp_q, resp_d;
    logic [BEAT_W-1:0]  burst_q, burst_d;
    logic               error_q, error_d;

    // Storage is deliberately left without reset.
    line_t              mem_q [DEPTH_LINES];
    line_t              mem_line_c;
    logic               mem_we_c;
    logic               req_live_c;
    logic               unused_addr_c;

    assign mem_line_c    = mem_q[idx_q];
    // The request line that must stay high is the one latched at acceptance.
    assign req_live_c    = wr_q ? write_i : read_i;
    assign unused_addr_c = ^{address_i[31:IDX_W+5], address_i[4:0]};

    // Next-state, datapath and output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        line_d   = line_q;
        error_d  = error_q;
        mem_we_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (read_i ^ write_i) begin
                    idx_d   = address_i[IDX_W+4:5];
                    wr_d    = write_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = S_WAIT;
                end else if (read_i & write_i) begin
                    error_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (!req_live_c) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == '0) begin
                    state_d = S_BURST;
                    beat_d  = 2'd0;
                    if (!wr_q) begin
                        line_d = mem_line_c;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_BURST: begin
                if (!req_live_c) begin
                    // Beats committed on earlier edges stay in storage.
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    mem_we_c = wr_q;
                    beat_d   = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                beat_d  = 2'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they depend on flops only.
        resp_d  = (state_d == S_BURST);
        burst_d = (resp_d && !wr_d) ? line_d[beat_d] : '0;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            line_q  <= '0;
            resp_q  <= 1'b0;
            burst_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            line_q  <= line_d;
            resp_q  <= resp_d;
            burst_q <= burst_d;
            error_q <= error_d;
        end
    end

    // Beat-granular storage write.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[idx_q][beat_q] <= burst_i;
        end
    end

    assign resp_o  = resp_q;
    assign burst_o = burst_q;
    assign error_o = error_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
module tb_burst_mem_responder;

    localparam int unsigned L     = 10;
    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address_i = '0;
    logic        read_i = 1'b0;
    logic        write_i = 1'b0;
    logic [63:0] burst_i = '0;
    logic [63:0] burst_o;
    logic        resp_o;
    logic        error_o;

    burst_mem_responder #(.DEPTH_LINES(DEPTH), .LATENCY(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .resp_o    (resp_o),
        .error_o   (error_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [63:0] data;
        bit          chk;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model_mem [DEPTH][4];
    bit          known     [DEPTH][4];
    bit          exp_err = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32) % DEPTH);
    endfunction

    // Monitor: compares every cycle's outputs against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        check("error_o", 64'(error_o), 64'(exp_err));
        if (resp_o) begin
            if (sb.size() == 0) begin
                check("unexpected resp_o", 64'(resp_o), 64'(0));
            end else begin
                e = sb.pop_front();
                check("resp cycle", 64'(cyc), 64'(e.cyc));
                if (e.chk) check("burst_o beat", burst_o, e.data);
            end
        end else begin
            check("burst_o idle", burst_o, 64'(0));
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                check("missing resp_o", 64'(resp_o), 64'(1));
                void'(sb.pop_front());
            end
        end
    end

    // One transaction; keep<4 drops the request during beat 'keep'.
    task automatic txn(input bit wr, input logic [31:0] addr,
                       input logic [3:0][63:0] d, input int keep);
        int   c;
        int   ix;
        int   beat;
        exp_t e;
        @(posedge clk); #1;
        c  = cyc;
        ix = idx_of(addr);
        address_i = addr;
        read_i    = !wr;
        write_i   = wr;
        for (int k = 0; k < 4; k++) begin
            if (k <= keep) begin
                e.cyc  = c + L + 1 + k;
                e.data = wr ? 64'(0) : model_mem[ix][k];
                e.chk  = wr || known[ix][k];
                sb.push_back(e);
            end
        end
        if (wr) begin
            for (int k = 0; k < 4; k++) begin
                if (k < keep) begin
                    model_mem[ix][k] = d[k];
                    known[ix][k]     = 1'b1;
                end
            end
        end
        while (cyc < c + L + 5) begin
            @(posedge clk); #1;
            beat = cyc - (c + L + 1);
            address_i = $urandom();
            burst_i   = {$urandom(), $urandom()};
            if (beat >= 0 && beat < 4) burst_i = d[beat];
            if (keep < 4 && beat == keep) begin
                read_i  = 1'b0;
                write_i = 1'b0;
            end
            if (keep < 4 && beat == keep + 1) exp_err = 1'b1;
        end
        read_i  = 1'b0;
        write_i = 1'b0;
    endtask

    function automatic logic [3:0][63:0] rnd_line();
        logic [3:0][63:0] d;
        for (int k = 0; k < 4; k++) d[k] = {$urandom(), $urandom()};
        return d;
    endfunction

    function automatic logic [31:0] rnd_addr(input int ix);
        return ($urandom() & 32'hFFFF_E000) | (32'(ix) << 5) | ($urandom() & 32'h1F);
    endfunction

    initial begin
        logic [3:0][63:0] d;
        logic [3:0][63:0] z;
        int               c;
        exp_t             e;
        z = '0;

        #1;
        check("reset resp_o", 64'(resp_o), 64'(0));
        check("reset burst_o", burst_o, 64'(0));
        check("reset error_o", 64'(error_o), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Basic write then read of line 0x40.
        d[0] = 64'h1111_1111_1111_1111;
        d[1] = 64'h2222_2222_2222_2222;
        d[2] = 64'h3333_3333_3333_3333;
        d[3] = 64'h4444_4444_4444_4444;
        txn(1'b1, 32'h0000_0040, d, 4);
        txn(1'b0, 32'h0000_0040, z, 4);
        // Back-to-back read, issued at the earliest legal cycle.
        txn(1'b0, 32'h0000_0040, z, 4);

        // Aliasing: 0x2000 maps to line 0, 0x20 to line 1.
        txn(1'b1, 32'h0000_2000, rnd_line(), 4);
        txn(1'b1, 32'h0000_0020, rnd_line(), 4);
        txn(1'b0, 32'h0000_0000, z, 4);
        txn(1'b0, 32'h0000_0020, z, 4);

        // Both request lines high in IDLE.
        @(posedge clk); #1;
        read_i  = 1'b1;
        write_i = 1'b1;
        @(posedge clk); #1;
        exp_err = 1'b1;
        read_i  = 1'b0;
        write_i = 1'b0;
        repeat (2) @(posedge clk);
        txn(1'b0, 32'h0000_0040, z, 4);

        // Write dropped after beat 1, then read the partially updated line.
        txn(1'b1, 32'h0000_0040, rnd_line(), 2);
        txn(1'b0, 32'h0000_0040, z, 4);

        // Randomized traffic over a small set of lines with aliased addresses.
        for (int i = 0; i < 30; i++) begin
            txn(1'(($urandom() & 3) != 0 ? 0 : 1) ^ 1'(i < 8), rnd_addr($urandom_range(0, 7)), rnd_line(), 4);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // Reset during beat 2 of a read.
        @(posedge clk); #1;
        c = cyc;
        address_i = 32'h0000_0040;
        read_i    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            e.cyc  = c + L + 1 + k;
            e.data = model_mem[2][k];
            e.chk  = known[2][k];
            sb.push_back(e);
        end
        while (cyc < c + L + 3) begin
            @(posedge clk); #1;
        end
        #1 rst = 1'b0;
        exp_err = 1'b0;
        #1;
        check("rst resp_o", 64'(resp_o), 64'(0));
        check("rst burst_o", burst_o, 64'(0));
        check("rst error_o", 64'(error_o), 64'(0));
        @(posedge clk); #1;
        rst    = 1'b1;
        read_i = 1'b0;
        txn(1'b0, 32'h0000_0040, z, 4);

        for (int i = 0; i < 10; i++) begin
            txn(1'($urandom() & 1), rnd_addr($urandom_range(0, 7)), rnd_line(), 4);
        end

        repeat (5) @(posedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
